// File: rtl/vga_fb_arb_pkg.sv
// vga_fb_arb shared package: default geometry, clear FSM state
// and the framebuffer address helper.
package vga_pkg;

  localparam int HOR_DEF   = 640;
  localparam int VER_DEF   = 480;
  localparam int RGB_W_DEF = 15;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  function automatic int unsigned pix_addr(
    input int unsigned h,
    input int unsigned v,
    input int unsigned hor
  );
    return v * hor + h;
  endfunction

endpackage

// File: rtl/vga_fb_arb_if.sv
// vga_fb_arb framebuffer RAM bus: single port, one-cycle
// synchronous read.
interface vga_fb_arb_if
  import vga_pkg::*;
#(
  parameter int RGB_WIDTH = RGB_W_DEF,
  parameter int ADDR_W    = 19
);

  logic                 en;
  logic                 we;
  logic [ADDR_W-1:0]    addr;
  logic [RGB_WIDTH-1:0] wdata;
  logic [RGB_WIDTH-1:0] rdata;

  modport master (
    output en, we, addr, wdata,
    input  rdata
  );

  modport slave (
    input  en, we, addr, wdata,
    output rdata
  );

endinterface

// File: rtl/vga_fb_arb_rd_pipe.sv
// vga_fb_rd_pipe: two-stage read return, rdata captured one
// cycle after the request, out-of-range pixels return zero.
module vga_fb_rd_pipe
  import vga_pkg::*;
#(
  parameter int RGB_WIDTH = RGB_W_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req,
  input  logic                 i_ok,
  input  logic [RGB_WIDTH-1:0] i_rdata,
  output logic [RGB_WIDTH-1:0] o_rgb,
  output logic                 o_valid
);

  logic                 v1_q, v1_d;
  logic                 ok1_q, ok1_d;
  logic                 valid_q, valid_d;
  logic [RGB_WIDTH-1:0] rgb_q, rgb_d;

  // Advance the pipe; o_rgb only changes with a valid pulse.
  always_comb begin
    v1_d    = i_req;
    ok1_d   = i_ok;
    valid_d = v1_q;
    rgb_d   = rgb_q;
    if (v1_q) begin
      rgb_d = ok1_q ? i_rdata : '0;
    end
  end

  // Pipe registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1_q    <= 1'b0;
      ok1_q   <= 1'b0;
      valid_q <= 1'b0;
      rgb_q   <= '0;
    end else begin
      v1_q    <= v1_d;
      ok1_q   <= ok1_d;
      valid_q <= valid_d;
      rgb_q   <= rgb_d;
    end
  end

  assign o_rgb   = rgb_q;
  assign o_valid = valid_q;

endmodule

// File: rtl/vga_fb_arb.sv
// vga_fb_arb: framebuffer RAM arbiter. Display fetch first,
// then the clear engine, then host writes.
module vga_fb_arb
  import vga_pkg::*;
#(
  parameter int HOR       = HOR_DEF,
  parameter int VER       = VER_DEF,
  parameter int RGB_WIDTH = RGB_W_DEF,
  parameter int ADDR_W    = $clog2(HOR * VER),
  localparam int HW       = $clog2(HOR) + 1,
  localparam int VW       = $clog2(VER) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pix_req,
  input  logic [HW-1:0]        i_pix_h,
  input  logic [VW-1:0]        i_pix_v,
  output logic [RGB_WIDTH-1:0] o_rgb,
  output logic                 o_valid,
  input  logic                 i_wr_valid,
  input  logic [ADDR_W-1:0]    i_wr_addr,
  input  logic [RGB_WIDTH-1:0] i_wr_data,
  output logic                 o_wr_ready,
  input  logic                 i_clr_start,
  input  logic [RGB_WIDTH-1:0] i_clr_rgb,
  output logic                 o_clr_busy,
  vga_fb_arb_if.master         mem
);

  localparam int TOTAL = HOR * VER;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TOTAL - 1);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    cnt_q, cnt_d;
  logic [RGB_WIDTH-1:0] clr_rgb_q, clr_rgb_d;
  logic                 busy_q, busy_d;

  logic pix_ok;
  logic wr_ok;
  logic clr_go;
  logic wr_go;

  // Per-cycle grant; RAM outputs follow it combinationally.
  always_comb begin
    pix_ok = (32'(i_pix_h) < HOR) && (32'(i_pix_v) < VER);
    wr_ok  = 32'(i_wr_addr) < TOTAL;
    clr_go = !i_pix_req && (state_q == CLEAR);
    wr_go  = !i_pix_req && (state_q == IDLE) && i_wr_valid;
    o_wr_ready = 1'b0;
    mem.en     = 1'b0;
    mem.we     = 1'b0;
    mem.addr   = '0;
    mem.wdata  = '0;
    if (!i_rst) begin
      o_wr_ready = !i_pix_req && (state_q == IDLE);
      unique case (1'b1)
        i_pix_req: begin
          mem.en   = pix_ok;
          mem.addr = pix_ok ?
            ADDR_W'(pix_addr(32'(i_pix_h), 32'(i_pix_v), HOR)) : '0;
        end
        clr_go: begin
          mem.en    = 1'b1;
          mem.we    = 1'b1;
          mem.addr  = cnt_q;
          mem.wdata = clr_rgb_q;
        end
        wr_go: begin
          mem.en    = wr_ok;
          mem.we    = wr_ok;
          mem.addr  = wr_ok ? i_wr_addr : '0;
          mem.wdata = wr_ok ? i_wr_data : '0;
        end
        default: ;
      endcase
    end
  end

  // Clear engine next state; it loses cycles to display fetch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_rgb_d = clr_rgb_q;
    unique case (state_q)
      IDLE: begin
        if (i_clr_start) begin
          state_d   = CLEAR;
          cnt_d     = '0;
          clr_rgb_d = i_clr_rgb;
        end
      end
      CLEAR: begin
        if (!i_pix_req) begin
          if (cnt_q == LAST) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CLEAR);
  end

  // Clear engine state and registered busy flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      clr_rgb_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_rgb_q <= clr_rgb_d;
      busy_q    <= busy_d;
    end
  end

  assign o_clr_busy = busy_q;

  vga_fb_rd_pipe #(
    .RGB_WIDTH(RGB_WIDTH)
  ) u_rd_pipe (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_req  (i_pix_req),
    .i_ok   (pix_ok),
    .i_rdata(mem.rdata),
    .o_rgb  (o_rgb),
    .o_valid(o_valid)
  );

endmodule
